// File: rtl/tank_level_controller.sv
// rtl/tank_level_controller.sv - closed-loop fill/consume supervisor for one tank
//
// Primes an empty tank, keeps the level inside a LOW_TH..HIGH_TH hysteresis
// band, drains on overfill, gates consumer demand on a safe level, and latches
// a fault on a persistent tank error or a fill that stops raising the level.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   enable       run request; 0 returns to IDLE (the only exit from FAULT)
//   demand       consumer wants to draw
//   height       tank level, unsigned
//   error        tank out-of-range flag
//   fill         registered fill drive to the tank
//   consume      registered consume drive to the tank
//   alarm        registered, 1 while in FAULT
//   state        IDLE=0, PRIME=1, REGULATE=2, DRAIN=3, FAULT=4
//   cons_count   saturating count of cycles with consume=1

module tank_level_controller #(
   parameter int unsigned LOW_TH       = 40,
   parameter int unsigned HIGH_TH      = 90,
   parameter int unsigned MAX_H        = 100,
   parameter int unsigned MIN_H        = 30,
   parameter int unsigned ERR_LIMIT    = 4,
   parameter int unsigned FILL_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        demand,
   input  logic [7:0]  height,
   input  logic        error,
   output logic        fill,
   output logic        consume,
   output logic        alarm,
   output logic [2:0]  state,
   output logic [15:0] cons_count
);

   localparam int unsigned ERR_W = $clog2(ERR_LIMIT + 1);
   localparam int unsigned WD_W  = $clog2(FILL_TIMEOUT + 1);

   // Counters fault when the *next* value would hit the limit, so compare
   // the current value against limit-1.
   localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_LIMIT - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(FILL_TIMEOUT - 1);

   localparam logic [7:0] LOW_H  = 8'(LOW_TH);
   localparam logic [7:0] HIGH_H = 8'(HIGH_TH);
   localparam logic [7:0] MAX_HB = 8'(MAX_H);
   localparam logic [7:0] MIN_HB = 8'(MIN_H);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRIME    = 3'd1,
      ST_REGULATE = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_FAULT    = 3'd4
   } state_t;

   state_t           state_q;
   logic             fill_q;
   logic             consume_q;
   logic             alarm_q;
   logic [15:0]      cons_count_q, cons_count_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [7:0]       prev_q;
   logic             err_fault;
   logic             wd_fault;
   logic             band_fill_d;
   logic             gated_consume_d;

   always_comb begin
      // Error counter only runs once the tank is primed; it reports error
      // while filling from empty.
      err_cnt_d = '0;
      err_fault = 1'b0;
      if ((state_q == ST_REGULATE || state_q == ST_DRAIN) && error) begin
         if (err_cnt_q == ERR_LAST) begin
            err_fault = 1'b1;
         end else begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
         end
      end

      // Watchdog counts fill cycles that fail to raise the level.
      wd_d     = '0;
      wd_fault = 1'b0;
      if (fill_q && (state_q == ST_PRIME || state_q == ST_REGULATE) &&
          !(height > prev_q)) begin
         if (wd_q == WD_LAST) begin
            wd_fault = 1'b1;
         end else begin
            wd_d = wd_q + WD_W'(1);
         end
      end

      // Hysteresis: set below LOW, clear at/above HIGH, hold in between.
      if (height < LOW_H) begin
         band_fill_d = 1'b1;
      end else if (height >= HIGH_H) begin
         band_fill_d = 1'b0;
      end else begin
         band_fill_d = fill_q;
      end

      gated_consume_d = demand && (height > MIN_HB);

      cons_count_d = cons_count_q;
      if (consume_q && cons_count_q != 16'hFFFF) begin
         cons_count_d = cons_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         fill_q       <= 1'b0;
         consume_q    <= 1'b0;
         alarm_q      <= 1'b0;
         cons_count_q <= '0;
         err_cnt_q    <= '0;
         wd_q         <= '0;
         prev_q       <= '0;
      end else begin
         prev_q       <= height;
         cons_count_q <= cons_count_d;

         if (err_fault || wd_fault) begin
            state_q   <= ST_FAULT;
            fill_q    <= 1'b0;
            consume_q <= 1'b0;
            alarm_q   <= 1'b1;
            err_cnt_q <= '0;
            wd_q      <= '0;
         end else if (!enable) begin
            state_q   <= ST_IDLE;
            fill_q    <= 1'b0;
            consume_q <= 1'b0;
            alarm_q   <= 1'b0;
            err_cnt_q <= '0;
            wd_q      <= '0;
         end else begin
            err_cnt_q <= err_cnt_d;
            wd_q      <= wd_d;
            case (state_q)
               ST_IDLE: begin
                  state_q   <= ST_PRIME;
                  fill_q    <= 1'b1;
                  consume_q <= 1'b0;
                  alarm_q   <= 1'b0;
               end
               ST_PRIME: begin
                  alarm_q <= 1'b0;
                  if (height >= LOW_H) begin
                     state_q   <= ST_REGULATE;
                     fill_q    <= band_fill_d;
                     consume_q <= gated_consume_d;
                  end else begin
                     fill_q    <= 1'b1;
                     consume_q <= 1'b0;
                  end
               end
               ST_REGULATE: begin
                  alarm_q <= 1'b0;
                  if (height > MAX_HB) begin
                     state_q   <= ST_DRAIN;
                     fill_q    <= 1'b0;
                     consume_q <= 1'b1;
                  end else begin
                     fill_q    <= band_fill_d;
                     consume_q <= gated_consume_d;
                  end
               end
               ST_DRAIN: begin
                  alarm_q <= 1'b0;
                  fill_q  <= 1'b0;
                  if (height <= HIGH_H) begin
                     state_q   <= ST_REGULATE;
                     consume_q <= gated_consume_d;
                  end else begin
                     consume_q <= 1'b1;
                  end
               end
               ST_FAULT: begin
                  fill_q    <= 1'b0;
                  consume_q <= 1'b0;
                  alarm_q   <= 1'b1;
               end
               default: begin
                  state_q   <= ST_IDLE;
                  fill_q    <= 1'b0;
                  consume_q <= 1'b0;
                  alarm_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign fill       = fill_q;
   assign consume    = consume_q;
   assign alarm      = alarm_q;
   assign state      = state_q;
   assign cons_count = cons_count_q;

endmodule
